rs_entry_pair: RTL and testbench



---
 rtl/rs_entry_pair.sv | 166 ++++++++++++++++
 tb/tb_rs_entry_pair.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_entry_pair.sv
// Two-entry reservation station slice: captures dispatched payloads, snoops two CDB
// ports to fill pending operands, and issues the oldest ready entry over valid/ready.
module rs_entry_pair #(
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [2*XLEN+11:0]  wr_data_0,
  input  logic                wr_valid_0,
  input  logic [TAG_W-1:0]    wr_tag_0,
  input  logic [2*XLEN+11:0]  wr_data_1,
  input  logic                wr_valid_1,
  input  logic [TAG_W-1:0]    wr_tag_1,
  output logic                empty_0,
  output logic                empty_1,
  input  logic                cdb0_valid,
  input  logic [TAG_W-1:0]    cdb0_tag,
  input  logic [XLEN-1:0]     cdb0_data,
  input  logic                cdb1_valid,
  input  logic [TAG_W-1:0]    cdb1_tag,
  input  logic [XLEN-1:0]     cdb1_data,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [2*XLEN+11:0]  iss_data,
  output logic [TAG_W-1:0]    iss_tag,
  output logic                iss_sel,
  output logic                wr_err
);

  localparam int PW    = 2*XLEN + 12;
  localparam int S1_V  = 0;
  localparam int S2_V  = XLEN + 1;
  localparam int S2_HI = 2*XLEN + 1;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} ent_state_e;

  ent_state_e         state_q [2];
  ent_state_e         state_d [2];
  logic [PW-1:0]      data_q  [2];
  logic [TAG_W-1:0]   tag_q   [2];
  logic               age_q;        // index of the older entry
  logic               age_d;

  logic [PW-1:0]      wr_data [2];
  logic [TAG_W-1:0]   wr_tag  [2];
  logic               wr_valid[2];
  logic [PW-1:0]      cand    [2];
  logic               cand_rdy[2];
  logic               alloc   [2];
  logic               occ_d   [2];
  logic               rdy     [2];
  logic               err_set;
  logic               sel;
  logic               xfer;

  assign wr_data[0]  = wr_data_0;
  assign wr_data[1]  = wr_data_1;
  assign wr_tag[0]   = wr_tag_0;
  assign wr_tag[1]   = wr_tag_1;
  assign wr_valid[0] = wr_valid_0;
  assign wr_valid[1] = wr_valid_1;

  // Operand slice is {value, valid}; a pending operand carries its producer tag in value.
  function automatic logic [XLEN:0] resolve(
    input logic [XLEN:0]   op,
    input logic            c0_v,
    input logic [TAG_W-1:0] c0_t,
    input logic [XLEN-1:0] c0_d,
    input logic            c1_v,
    input logic [TAG_W-1:0] c1_t,
    input logic [XLEN-1:0] c1_d
  );
    logic [XLEN:0] r;
    r = op;
    if (!op[0]) begin
      if (c0_v && c0_t == op[TAG_W:1])      r = {c0_d, 1'b1};
      else if (c1_v && c1_t == op[TAG_W:1]) r = {c1_d, 1'b1};
    end
    return r;
  endfunction

  // Candidate contents: the incoming payload when empty, otherwise the stored one,
  // with CDB results merged in. This shares one snoop path for bypass and wakeup.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      // NOTE: every combinational output is assigned on every path so no latch is inferred.
      cand[k] = (state_q[k] == S_EMPTY) ? wr_data[k] : data_q[k];
      cand[k][XLEN:0] = resolve(cand[k][XLEN:0], cdb0_valid, cdb0_tag, cdb0_data,
                                cdb1_valid, cdb1_tag, cdb1_data);
      cand[k][S2_HI:S2_V] = resolve(cand[k][S2_HI:S2_V], cdb0_valid, cdb0_tag, cdb0_data,
                                    cdb1_valid, cdb1_tag, cdb1_data);
      cand_rdy[k] = cand[k][S1_V] && cand[k][S2_V];
    end
  end

  assign rdy[0]    = (state_q[0] == S_READY);
  assign rdy[1]    = (state_q[1] == S_READY);
  assign sel       = (rdy[0] && rdy[1]) ? age_q : rdy[1];
  assign iss_valid = (rdy[0] || rdy[1]) && !flush;
  assign xfer      = iss_valid && iss_ready;
  assign iss_sel   = iss_valid & sel;
  assign iss_data  = iss_valid ? data_q[sel] : '0;
  assign iss_tag   = iss_valid ? tag_q[sel]  : '0;
  assign empty_0   = (state_q[0] == S_EMPTY);
  assign empty_1   = (state_q[1] == S_EMPTY);

  always_comb begin
    err_set = 1'b0;
    for (int k = 0; k < 2; k++) begin
      alloc[k]   = 1'b0;
      state_d[k] = state_q[k];
      if (flush) begin
        state_d[k] = S_EMPTY;
      end else begin
        case (state_q[k])
          S_EMPTY: if (wr_valid[k]) begin
            alloc[k]   = 1'b1;
            state_d[k] = cand_rdy[k] ? S_READY : S_WAIT;
          end
          S_WAIT:  if (cand_rdy[k]) state_d[k] = S_READY;
          S_READY: if (xfer && sel == k[0]) state_d[k] = S_EMPTY;
          default: state_d[k] = S_EMPTY;
        endcase
        // An entry being issued this cycle still counts as occupied.
        if (wr_valid[k] && state_q[k] != S_EMPTY) err_set = 1'b1;
      end
      occ_d[k] = (state_d[k] != S_EMPTY);
    end
  end

  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = 1'b0;
    end else if (occ_d[0] && occ_d[1]) begin
      if (alloc[0] != alloc[1]) age_d = alloc[0];
      else if (alloc[0])        age_d = 1'b0;
    end else if (occ_d[0] != occ_d[1]) begin
      age_d = occ_d[1];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) state_q[k] <= S_EMPTY;
      age_q  <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) state_q[k] <= state_d[k];
      age_q <= age_d;
      if (err_set) wr_err <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; it is only observable while its entry is occupied.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (alloc[k] || (!flush && state_q[k] == S_WAIT)) data_q[k] <= cand[k];
      if (alloc[k]) tag_q[k] <= wr_tag[k];
    end
  end

endmodule

// File: tb/tb_rs_entry_pair.sv
// Bench for rs_entry_pair: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against an occupancy/sequence-number model.
module tb_rs_entry_pair;

  localparam int TAG_W = 5;
  localparam int XLEN  = 32;
  localparam int PW    = 76;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [PW-1:0]    wr_data_0, wr_data_1;
  logic             wr_valid_0, wr_valid_1;
  logic [TAG_W-1:0] wr_tag_0, wr_tag_1;
  logic             empty_0, empty_1;
  logic             cdb0_valid, cdb1_valid;
  logic [TAG_W-1:0] cdb0_tag, cdb1_tag;
  logic [XLEN-1:0]  cdb0_data, cdb1_data;
  logic             iss_valid, iss_ready, iss_sel, wr_err;
  logic [PW-1:0]    iss_data;
  logic [TAG_W-1:0] iss_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_entry_pair #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_data_0(wr_data_0), .wr_valid_0(wr_valid_0), .wr_tag_0(wr_tag_0),
    .wr_data_1(wr_data_1), .wr_valid_1(wr_valid_1), .wr_tag_1(wr_tag_1),
    .empty_0(empty_0), .empty_1(empty_1),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data),
    .iss_tag(iss_tag), .iss_sel(iss_sel), .wr_err(wr_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [4:0] aluop, input logic [4:0] ctl,
                                       input logic [31:0] s2, input logic s2v,
                                       input logic [31:0] s1, input logic s1v);
    return {aluop, ctl, s2, s2v, s1, s1v};
  endfunction

  // ---------------- reference model ----------------
  logic [PW-1:0]    m_pay [2];
  logic [TAG_W-1:0] m_tag [2];
  bit               m_occ [2];
  int unsigned      m_seq [2];
  int unsigned      seq_ctr = 0;
  bit               m_err = 1'b0;
  bit               cmp_en = 1'b0;

  function automatic logic [PW-1:0] fill(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    if (!r[0]) begin
      if (cdb0_valid && cdb0_tag == r[5:1])      begin r[32:1] = cdb0_data; r[0] = 1'b1; end
      else if (cdb1_valid && cdb1_tag == r[5:1]) begin r[32:1] = cdb1_data; r[0] = 1'b1; end
    end
    if (!r[33]) begin
      if (cdb0_valid && cdb0_tag == r[38:34])      begin r[65:34] = cdb0_data; r[33] = 1'b1; end
      else if (cdb1_valid && cdb1_tag == r[38:34]) begin r[65:34] = cdb1_data; r[33] = 1'b1; end
    end
    return r;
  endfunction

  function automatic bit m_ready(input int k);
    return m_occ[k] && m_pay[k][0] && m_pay[k][33];
  endfunction

  // Oldest ready entry, or -1 when nothing is ready.
  function automatic int m_pick();
    if (m_ready(0) && m_ready(1)) return (m_seq[0] < m_seq[1]) ? 0 : 1;
    if (m_ready(0)) return 0;
    if (m_ready(1)) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [PW-1:0]    np [2];
    logic [TAG_W-1:0] nt [2];
    bit               no [2];
    int unsigned      ns [2];
    int unsigned      nseq;
    bit               nerr;
    bit               xfer;
    int               s;
    for (int k = 0; k < 2; k++) begin
      np[k] = m_pay[k]; nt[k] = m_tag[k]; no[k] = m_occ[k]; ns[k] = m_seq[k];
    end
    nseq = seq_ctr;
    nerr = m_err;
    if (rst) begin
      no[0] = 1'b0; no[1] = 1'b0; nerr = 1'b0;
      cmp_en <= 1'b1;
    end else if (flush) begin
      no[0] = 1'b0; no[1] = 1'b0;
    end else begin
      s    = m_pick();
      xfer = (s >= 0) && iss_ready;
      for (int k = 0; k < 2; k++) if (m_occ[k]) np[k] = fill(m_pay[k]);
      if (wr_valid_0) begin
        if (m_occ[0]) nerr = 1'b1;
        else begin no[0] = 1'b1; np[0] = fill(wr_data_0); nt[0] = wr_tag_0; ns[0] = nseq; nseq++; end
      end
      if (wr_valid_1) begin
        if (m_occ[1]) nerr = 1'b1;
        else begin no[1] = 1'b1; np[1] = fill(wr_data_1); nt[1] = wr_tag_1; ns[1] = nseq; nseq++; end
      end
      if (xfer) no[s] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      m_pay[k] <= np[k]; m_tag[k] <= nt[k]; m_occ[k] <= no[k]; m_seq[k] <= ns[k];
    end
    seq_ctr <= nseq;
    m_err   <= nerr;
  end

  task automatic compare_outputs();
    int s;
    int idx;
    bit v;
    s   = m_pick();
    v   = (s >= 0) && !flush;
    idx = (s < 0) ? 0 : s;
    check("cmp_empty_0", empty_0, !m_occ[0]);
    check("cmp_empty_1", empty_1, !m_occ[1]);
    check("cmp_iss_valid", iss_valid, v);
    check("cmp_iss_sel", iss_sel, v ? idx : 0);
    check("cmp_iss_tag", iss_tag, v ? m_tag[idx] : 5'd0);
    check("cmp_iss_data", iss_data, v ? m_pay[idx] : {PW{1'b0}});
    check("cmp_wr_err", wr_err, m_err);
  endtask

  always @(negedge clk) begin
    #2;
    if (cmp_en) compare_outputs();
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    flush = 1'b0; iss_ready = 1'b0;
    wr_valid_0 = 1'b0; wr_tag_0 = '0; wr_data_0 = '0;
    wr_valid_1 = 1'b0; wr_tag_1 = '0; wr_data_1 = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
  endtask

  function automatic logic [PW-1:0] rnd_pay();
    logic [31:0] s1, s2;
    logic        v1, v2;
    s1 = $urandom; s2 = $urandom;
    v1 = 1'($urandom_range(0, 1));
    v2 = 1'($urandom_range(0, 1));
    if (!v1) s1[4:0] = 5'($urandom_range(0, 3));
    if (!v2) s2[4:0] = 5'($urandom_range(0, 3));
    return mk(5'($urandom), 5'($urandom), s2, v2, s1, v1);
  endfunction

  logic [PW-1:0] p5, p6;

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_empty_0", empty_0, 1);
    check("rst_iss_valid", iss_valid, 0);

    // Ready issue: write-to-issue in one cycle, entry frees the cycle after transfer.
    @(negedge clk);
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd3; iss_ready = 1'b1;
    wr_data_0 = mk(5'd1, 5'd1, 32'h22, 1'b1, 32'h11, 1'b1);
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t1_valid", iss_valid, 1);
    check("t1_sel", iss_sel, 0);
    check("t1_tag", iss_tag, 3);
    check("t1_s1", iss_data[32:1], 32'h11);
    check("t1_busy", empty_0, 0);
    @(negedge clk); clr(); #2;
    check("t1_freed", empty_0, 1);
    check("t1_idle", iss_valid, 0);

    // Pending wakeup through cdb1.
    @(negedge clk);
    wr_valid_1 = 1'b1; wr_tag_1 = 5'd9; iss_ready = 1'b1;
    wr_data_1 = mk(5'd2, 5'd3, 32'h33, 1'b1, 32'h7, 1'b0);
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t2_wait", iss_valid, 0);
    check("t2_busy", empty_1, 0);
    @(negedge clk);
    cdb1_valid = 1'b1; cdb1_tag = 5'd7; cdb1_data = 32'hDEADBEEF; #2;
    check("t2_not_yet", iss_valid, 0);
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t2_valid", iss_valid, 1);
    check("t2_sel", iss_sel, 1);
    check("t2_tag", iss_tag, 9);
    check("t2_s1", iss_data[32:1], 32'hDEADBEEF);
    check("t2_s1v", iss_data[0], 1);
    @(negedge clk); clr(); #2;
    check("t2_freed", empty_1, 1);

    // Same-cycle bypass on cdb0.
    @(negedge clk);
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd12; iss_ready = 1'b1;
    wr_data_0 = mk(5'd3, 5'd0, 32'h4, 1'b0, 32'h1, 1'b1);
    cdb0_valid = 1'b1; cdb0_tag = 5'd4; cdb0_data = 32'h5;
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t3_valid", iss_valid, 1);
    check("t3_s2", iss_data[65:34], 32'h5);
    check("t3_s2v", iss_data[33], 1);
    @(negedge clk); clr(); #2;
    check("t3_freed", empty_0, 1);

    // Age ordering: entry 1 allocated first is offered first.
    @(negedge clk);
    wr_valid_1 = 1'b1; wr_tag_1 = 5'd1; wr_data_1 = mk(5'd4, 5'd0, 32'hA, 1'b1, 32'hB, 1'b1);
    @(negedge clk); clr();
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd2; wr_data_0 = mk(5'd5, 5'd0, 32'hC, 1'b1, 32'hD, 1'b1);
    #2; check("t4_first", iss_sel, 1);
    @(negedge clk); clr(); #2;
    check("t4_older_held", iss_sel, 1);
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t4_tag_a", iss_tag, 1);
    @(negedge clk); clr(); iss_ready = 1'b1; #2;
    check("t4_sel_b", iss_sel, 0);
    check("t4_tag_b", iss_tag, 2);
    @(negedge clk); clr(); #2;
    check("t4_drained", iss_valid, 0);

    // Back-pressure hold, then flush; a write during flush is dropped silently.
    p5 = mk(5'd6, 5'h15, 32'hCAFE, 1'b1, 32'hF00D, 1'b1);
    @(negedge clk);
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd5; wr_data_0 = p5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clr(); #2;
      check("t5_hold", iss_data, p5);
    end
    @(negedge clk); clr(); flush = 1'b1;
    wr_valid_1 = 1'b1; wr_data_1 = p5; #2;
    check("t5_flush_valid", iss_valid, 0);
    check("t5_flush_data", iss_data, 0);
    @(negedge clk); clr(); #2;
    check("t5_empty_0", empty_0, 1);
    check("t5_empty_1", empty_1, 1);
    check("t5_no_err", wr_err, 0);

    // Occupied-entry write is ignored and sticks wr_err; then reset mid-WAIT.
    p6 = mk(5'd7, 5'd1, 32'h66, 1'b1, 32'hA, 1'b0);
    @(negedge clk);
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd6; wr_data_0 = p6;
    @(negedge clk); clr();
    wr_valid_0 = 1'b1; wr_tag_0 = 5'd11; wr_data_0 = mk(5'd8, 5'd2, 32'h1, 1'b1, 32'h2, 1'b1);
    #2; check("t6_err_before", wr_err, 0);
    @(negedge clk); clr(); #2;
    check("t6_err_set", wr_err, 1);
    check("t6_ignored", iss_valid, 0);
    @(negedge clk);
    cdb0_valid = 1'b1; cdb0_tag = 5'd10; cdb0_data = 32'hABC;
    @(negedge clk); clr(); #2;
    check("t6_data", iss_data, {p6[75:33], 32'hABC, 1'b1});
    check("t6_tag", iss_tag, 6);
    check("t6_sticky", wr_err, 1);
    @(negedge clk); clr();
    wr_valid_1 = 1'b1; wr_tag_1 = 5'd13; wr_data_1 = mk(5'd9, 5'd0, 32'hD, 1'b0, 32'h1, 1'b1);
    @(negedge clk); clr(); rst = 1'b1; #2;
    check("t6_wait_busy", empty_1, 0);
    @(negedge clk); rst = 1'b0; #2;
    check("t6_rst_empty_0", empty_0, 1);
    check("t6_rst_empty_1", empty_1, 1);
    check("t6_rst_valid", iss_valid, 0);
    check("t6_rst_data", iss_data, 0);
    check("t6_rst_tag", iss_tag, 0);
    check("t6_rst_sel", iss_sel, 0);
    check("t6_rst_err", wr_err, 0);

    // Random traffic, checked by the compare process every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      wr_valid_0 = ($urandom_range(0, 2) == 0);
      wr_tag_0   = 5'($urandom);
      wr_data_0  = rnd_pay();
      wr_valid_1 = ($urandom_range(0, 2) == 0);
      wr_tag_1   = 5'($urandom);
      wr_data_1  = rnd_pay();
      cdb0_valid = 1'($urandom_range(0, 1));
      cdb0_tag   = 5'($urandom_range(0, 3));
      cdb0_data  = $urandom;
      cdb1_valid = 1'($urandom_range(0, 1));
      cdb1_tag   = 5'($urandom_range(0, 3));
      cdb1_data  = $urandom;
      iss_ready  = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); clr(); rst = 1'b0;
    @(negedge clk); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
